div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit restoring divider serving DIV/DIVU in the EX stage.
- Acts as the requester side of the pipeline stall/flush protocol: it raises the EX stall request while a division is in flight.
- It obeys the pipeline controller's flush as an annul input.
- Returns {remainder, quotient} for the HI/LO write path.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must be at least clog2(DATA_W)+1.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1_i  in  DATA_W  dividend; EX holds it stable while stalled.
- opdata2_i  in  DATA_W  divisor.
- start_i  in  1  division request; EX holds it high until it sees ready_o.
- annul_i  in  1  pipeline flush (exception or eret); aborts any in-flight operation.
- result_o  out  2*DATA_W  {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}.
- ready_o  out  1  result valid.
- stallreq_o  out  1  EX stall request to the pipeline controller.
- div_zero_o  out  1  divide-by-zero flag; exists only under the optional macro, tied 0 otherwise.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FREE; counter=0; result_o=0; ready_o=0; div_zero_o=0.
  - Internal dividend, divisor and sign latches are cleared.
- States: FREE, BYZERO, ON, END.
- FREE:
  - Stays in FREE if start_i=0 or annul_i=1.
  - On start_i=1 and annul_i=0 with opdata2_i==0: go to BYZERO.
  - On start_i=1 and annul_i=0 with any other divisor:
    - Latch the operands; when signed, latch absolute values (two's-complement negate where the MSB is 1).
    - Latch sign_q = sign1 XOR sign2 and sign_r = sign1.
    - Clear the partial remainder, set counter=0, go to ON.
- ON (one quotient bit per cycle, MSB first):
  - Shift {rem, dividend} left by 1.
  - Compute diff = {1'b0, rem_shifted} - {1'b0, divisor} at DATA_W+1 bits.
  - If diff is non-negative, rem = diff and the quotient bit = 1; otherwise rem is unchanged and the bit = 0.
  - Counter increments each cycle. After the step with counter==DATA_W-1, go to END. This is DATA_W cycles in ON.
  - annul_i=1: go to FREE immediately; outputs stay 0; partial state is discarded.
- BYZERO: next cycle go to END with the result forced to 0. annul_i=1 sends it to FREE instead.
- END:
  - ready_o=1 and result_o is valid, both registered.
  - Signed correction is applied at END entry: quotient negated if sign_q, remainder negated if sign_r.
  - Stays in END while start_i=1 and annul_i=0.
  - When start_i=0 or annul_i=1: go to FREE, ready_o=0, result_o=0, both in the same cycle.
- Latency: start sampled in FREE at cycle T.
  - Normal division: ready_o=1 at T+DATA_W+1 (T+33).
  - Divide by zero: ready_o=1 at T+2.
- stallreq_o = start_i & ~ready_o & ~annul_i (combinational).
  - Held high from the first start cycle until the result is ready.
  - Never asserted during a flush.
- Arithmetic rules:
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0 by wraparound; no trap.
  - Remainder sign always follows the dividend.
- Simultaneous events:
  - annul_i has priority over start_i in every state.
  - A new start is only accepted from FREE, so back-to-back divisions require one FREE cycle.

Optional Feature:
- Macro: DIV_ZERO_TRAP_EN.
- When defined:
  - div_zero_o pulses for exactly one cycle, the BYZERO cycle, when a zero divisor is accepted.
  - The EX stage uses the pulse to raise an exception cause.
  - result_o is still 0 and the handshake is unchanged.
- When undefined: div_zero_o is constant 0 and no extra logic is synthesised.

Decomposition:
- Shared defines file contents:
  - State encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady / DivResultNotReady, DivStart / DivStop.
  - The existing RstEnable and ZeroWord constants.
- One natural sub-module: div_sub_step.
  - Combinational single restoring iteration.
  - Inputs rem, next dividend bit, divisor.
  - Outputs new rem and quotient bit.
  - Instantiated once inside the ON datapath.

Test Plan:
- Unsigned 100/7, start at T, held: ready_o=1 at T+33, result_o={32'd2, 32'd14}, stallreq_o high T..T+32 and low at T+33.
- Signed -7/2 (0xFFFFFFF9 / 2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- 5/0: ready_o at T+2, result_o=0. With DIV_ZERO_TRAP_EN, div_zero_o=1 only at T+1.
- annul_i pulsed at T+10 during 100/7: state FREE at T+11, ready_o never rises. New 9/3 started at T+12 gives {0, 3} at T+45.
- rst driven low at T+20 mid-division: all outputs 0 asynchronously. After release, a fresh 10/3 gives {1, 3} 33 cycles after start.
- start_i held 5 extra cycles in END: ready_o and result stable for all 5. start_i dropped: ready_o=0 next edge, and no new division begins without a FREE cycle.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared encodings and constants for the EX-stage divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic RstEnable         = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0;

  // Correction flags captured at start: quotient sign, remainder sign.
  typedef struct packed {
    logic neg_q;
    logic neg_r;
  } div_sign_t;

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_sub_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dvd_bit_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_o
);

  logic [DATA_W:0]   part;
  logic [DATA_W+1:0] diff;
  logic              unused_hi;

  // Partial remainder keeps its carry-out so divisors with the MSB set work.
  assign part  = {rem_i, dvd_bit_i};
  assign diff  = {1'b0, part} - {2'b00, dvs_i};
  assign q_o   = ~diff[DATA_W+1];
  assign rem_o = q_o ? diff[DATA_W-1:0] : part[DATA_W-1:0];

  // Top bits are always 0 on the selected path (result < divisor).
  assign unused_hi = ^{diff[DATA_W], part[DATA_W]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; stalls EX while busy.
// Optional DIV_ZERO_TRAP_EN adds a one-cycle divide-by-zero pulse.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o,
  output logic                div_zero_o
);

  div_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   dvd_q, dvd_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  div_sign_t           sign_q, sign_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic                sign1, sign2;
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic [DATA_W-1:0]   step_rem;
  logic                step_q;
  logic [DATA_W-1:0]   q_next, quot_fix, rem_fix;

  assign sign1   = signed_div_i & opdata1_i[DATA_W-1];
  assign sign2   = signed_div_i & opdata2_i[DATA_W-1];
  assign op1_abs = sign1 ? -opdata1_i : opdata1_i;
  assign op2_abs = sign2 ? -opdata2_i : opdata2_i;

  // dvd_q shifts out dividend bits at the top and collects quotient bits below.
  div_sub_step #(.DATA_W(DATA_W)) u_step (
    .rem_i    (rem_q),
    .dvd_bit_i(dvd_q[DATA_W-1]),
    .dvs_i    (dvs_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  assign q_next   = {dvd_q[DATA_W-2:0], step_q};
  assign quot_fix = sign_q.neg_q ? -q_next   : q_next;
  assign rem_fix  = sign_q.neg_r ? -step_rem : step_rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sign_d   = sign_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == DATA_W'(ZeroWord)) begin
            state_d = DivByZero;
          end else begin
            dvd_d        = op1_abs;
            dvs_d        = op2_abs;
            sign_d.neg_q = sign1 ^ sign2;
            sign_d.neg_r = sign1;
            rem_d        = '0;
            cnt_d        = '0;
            state_d      = DivOn;
          end
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          state_d  = DivEnd;
          result_d = '0;
          ready_d  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_d = DivFree;
        end else begin
          rem_d = step_rem;
          dvd_d = q_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            state_d  = DivEnd;
            result_d = {rem_fix, quot_fix};
            ready_d  = DivResultReady;
          end
        end
      end
      DivEnd: begin
        if (annul_i || start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= DivFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      sign_q   <= '0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

`ifdef DIV_ZERO_TRAP_EN
  assign div_zero_o = (state_q == DivByZero);
`else
  assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results, monitor checks.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div, start, annul;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic        ready, stallreq, div_zero;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  int          due_q[$];
  logic        ready_prev = 1'b0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready),
    .stallreq_o  (stallreq),
    .div_zero_o  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, expv, cyc);
    end
  endtask

  // Monitor: on each rising ready, pop the scoreboard and compare value and timing.
  always @(negedge clk) begin
    logic [63:0] e;
    int          d;
    if (!rst) begin
      ready_prev = 1'b0;
    end else begin
      if (ready && !ready_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready got=%h cyc=%0d", result, cyc);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          chk("result", result, e);
          chk("latency", 64'(cyc), 64'(d));
        end
      end
      ready_prev = ready;
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input logic [63:0] e, input int lat, input int hold, input bit rst_end);
    int   t0, due;
    bit   seen;
    logic dz_e;
    @(posedge clk); #1;
    op1 = a; op2 = b; signed_div = sgn; start = 1'b1;
    t0  = cyc;
    due = t0 + lat;
    exp_q.push_back(e);
    due_q.push_back(due);
    seen = 1'b0;
    for (int k = 0; k < lat + 5 && !seen; k++) begin
      @(negedge clk);
      chk("stallreq", {63'd0, stallreq}, {63'd0, (cyc < due)});
`ifdef DIV_ZERO_TRAP_EN
      dz_e = (b == 32'd0) && (cyc == t0 + 1);
`else
      dz_e = 1'b0;
`endif
      chk("div_zero", {63'd0, div_zero}, {63'd0, dz_e});
      if (ready) seen = 1'b1;
    end
    chk("ready_seen", {63'd0, seen}, 64'd1);
    if (!seen && exp_q.size() != 0) begin
      void'(exp_q.pop_back());
      void'(due_q.pop_back());
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_ready", {63'd0, ready}, 64'd1);
      chk("hold_result", result, e);
    end
    if (rst_end) begin
      #1 rst = RstEnable;
      #1;
      chk("rst_end_ready", {63'd0, ready}, 64'd0);
      chk("rst_end_result", result, 64'd0);
      start = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
    end else begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("drop_ready_still", {63'd0, ready}, 64'd1);
      @(negedge clk);
      chk("drop_ready", {63'd0, ready}, 64'd0);
      chk("drop_result", result, 64'd0);
      @(negedge clk);
      chk("free_ready", {63'd0, ready}, 64'd0);
      chk("free_stall", {63'd0, stallreq}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = RstEnable; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", result, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    chk("rst_stall", {63'd0, stallreq}, 64'd0);
    chk("rst_divzero", {63'd0, div_zero}, 64'd0);
    rst = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 5, 1'b0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0, 1'b0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 0, 1'b0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, {32'h80000000, 32'h0}, 33, 0, 1'b0);
    run_div(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, {32'd1, 32'd1}, 33, 0, 1'b0);
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 33, 0, 1'b0);
    run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'hFFFFFFFE, 32'd14}, 33, 0, 1'b0);
    run_div(32'd5, 32'd0, 1'b0, 64'd0, 2, 1, 1'b0);
    run_div(32'd5, 32'd0, 1'b1, 64'd0, 2, 0, 1'b0);

    // Flush at T+10 of 100/7; nothing is pushed so any ready is flagged.
    @(posedge clk); #1;
    op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_stall", {63'd0, stallreq}, 64'd1);
    @(posedge clk); #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", {63'd0, stallreq}, 64'd0);
    chk("annul_ready", {63'd0, ready}, 64'd0);
    @(posedge clk); #1 annul = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("post_annul_ready", {63'd0, ready}, 64'd0);
    run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 0, 1'b0);

    // Asynchronous reset at T+20 of a fresh 100/7.
    @(posedge clk); #1;
    op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst = RstEnable;
    #1;
    chk("mid_rst_ready", {63'd0, ready}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_divzero", {63'd0, div_zero}, 64'd0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    run_div(32'd10, 32'd3, 1'b0, {32'd1, 32'd3}, 33, 0, 1'b0);

    run_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 2, 1'b1);
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
